// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encodings,
// result bus type and the handshake constants used by EX.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    // {remainder, quotient} as written to HI/LO
    typedef logic [63:0] div_result_bus_t;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam logic        Stop              = 1'b1;
    localparam logic        NoStop            = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring division iteration on the {partial remainder, dividend}
// working register. Purely combinational.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  work_i,
    input  logic [DATA_W-1:0]  divisor_i,
    output logic [2*DATA_W:0]  work_o
);

    // The shifted upper part never exceeds 2*divisor, so a sign bit on top of
    // the (DATA_W+1)-bit trial value is enough to detect a borrow.
    logic [DATA_W+1:0] trial;
    logic [DATA_W+1:0] diff;

    // shift left, trial-subtract, keep the difference or restore
    always_comb begin
        trial = work_i[2*DATA_W:DATA_W-1];
        diff  = trial - {2'b00, divisor_i};
        if (diff[DATA_W+1]) begin
            work_o = {work_i[2*DATA_W-1:DATA_W-1], work_i[DATA_W-2:0], 1'b0};
        end else begin
            work_o = {diff[DATA_W:0], work_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o output.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic                div_zero_o,
`endif
    output logic                stallreq_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

    div_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   work;
    logic [2*DATA_W:0]   work_next;
    logic [DATA_W-1:0]   divisor_r;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    div_step #(.DATA_W(DATA_W)) u_step (
        .work_i    (work),
        .divisor_i (divisor_r),
        .work_o    (work_next)
    );

    // operand magnitudes; the most negative value maps onto itself and is
    // then read as the unsigned magnitude 2^(DATA_W-1)
    always_comb begin
        abs_a = (signed_i && dividend_i[DATA_W-1]) ? (~dividend_i + 1'b1) : dividend_i;
        abs_b = (signed_i && divisor_i[DATA_W-1])  ? (~divisor_i + 1'b1)  : divisor_i;
    end

    // sign restoration of the final step's result, wrapping modulo 2^DATA_W
    always_comb begin
        quot_fix = work_next[DATA_W-1:0];
        rem_fix  = work_next[2*DATA_W-1:DATA_W];
        if (sign_a ^ sign_b) quot_fix = ~quot_fix + 1'b1;
        if (sign_a)          rem_fix  = ~rem_fix + 1'b1;
    end

    // EX is stalled until the result is presented, unless the op is flushed
    always_comb begin
        stallreq_o = (start_i == DivStart && ready_o == DivResultNotReady && !annul_i) ? Stop : NoStop;
    end

    // sequencer: operand capture, iteration, fixup and result hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DIV_IDLE;
            cnt        <= '0;
            work       <= '0;
            divisor_r  <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            ready_o    <= DivResultNotReady;
            result_o   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (divisor_i == ZeroWord) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state     <= DIV_ON;
                            cnt       <= '0;
                            work      <= {{(DATA_W+1){1'b0}}, abs_a};
                            divisor_r <= abs_b;
                            sign_a    <= signed_i & dividend_i[DATA_W-1];
                            sign_b    <= signed_i & divisor_i[DATA_W-1];
                        end
                    end
                end
                DIV_BYZERO: begin
                    state    <= DIV_END;
                    ready_o  <= DivResultReady;
                    result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_o <= 1'b1;
`endif
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_IDLE;
                    end else begin
                        work <= work_next;
                        cnt  <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state    <= DIV_END;
                            ready_o  <= DivResultReady;
                            result_o <= {rem_fix, quot_fix};
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DivStop || annul_i) begin
                        state    <= DIV_IDLE;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_o <= 1'b0;
`endif
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected {rem, quot}
// values pushed at issue time and popped when ready_o rises.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero_o (div_zero_o),
`endif
        .stallreq_o (stallreq_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model built on the language's truncating division
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int          sq, sr;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            q  = sq;
            r  = sr;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // issue one divide, wait for ready, compare, optionally hold in END, release
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int lat, input int hold);
        logic [63:0] e;
        logic [63:0] held;
        logic        stall_ok;
        int          n;
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = sgn;
        start_i    = 1'b1;
        exp_q.push_back(model(a, b, sgn));
        #1 stall_ok = stallreq_o;
        n = 0;
        while (!ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            // operands must only matter on the accept cycle
            dividend_i = $urandom;
            divisor_i  = $urandom;
            signed_i   = $urandom_range(0, 1);
            if (!ready_o) stall_ok &= stallreq_o;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("stall_during_op", 64'(stall_ok), 64'd1);
        chk("stall_low_at_ready", 64'(stallreq_o), 64'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", result_o, e);
        end
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero_flag", 64'(div_zero_o), 64'(b == 32'd0));
`endif
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 64'(ready_o), 64'd1);
            chk("hold_result", result_o, held);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("release_ready", 64'(ready_o), 64'd0);
        chk("release_result", result_o, 64'd0);
        chk("release_stall", 64'(stallreq_o), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("release_flag", 64'(div_zero_o), 64'd0);
`endif
    endtask

    initial begin
        logic       seen;
        logic       stall_seen;
        logic [31:0] ra, rb;
        logic        rs;
        rst        = 1'b1;
        start_i    = 1'b0;
        annul_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed divides
        do_div(32'd100, 32'd7, 1'b0, 33, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 0);
        do_div(32'd5, 32'd0, 1'b0, 2, 0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 33, 0);
        do_div(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 33, 0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 33, 0);
        do_div(32'd3, 32'd10, 1'b0, 33, 0);
        do_div(32'd100, 32'd7, 1'b0, 33, 5);

        // annul mid-operation: no result, block returns to idle
        @(negedge clk);
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1 chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 seen |= ready_o;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, 33, 0);

        // reset in the middle of a divide
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd9;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_stall_hi", 64'(stallreq_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        #1 chk("midrst_stall_lo", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_seen = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 seen |= ready_o;
        end
        chk("midrst_no_ready", 64'(seen), 64'd0);
        do_div(32'd1000, 32'd9, 1'b0, 33, 0);

        // random operands in both modes
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = $urandom_range(0, 1);
            do_div(ra, rb, rs, (rb == 32'd0) ? 2 : 33, 0);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit radix-2 restoring divider and sequencer for DIV/DIVU, attached to the EX stage.
- EX raises start_i with the operands; the block asserts stallreq_o until the result is ready, then returns {remainder, quotient} for the HI/LO write.
- Owns the iteration counter, operand conditioning (sign handling), and annul on pipeline flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  divide request; EX holds it high for the whole operation
- annul_i  in  1  flush; cancels the operation in progress
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- dividend_i  in  DATA_W  rs operand, sampled only on the accept cycle
- divisor_i  in  DATA_W  rt operand, sampled only on the accept cycle
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
- ready_o  out  1  result valid, registered
- stallreq_o  out  1  combinational: start_i & ~ready_o & ~annul_i

Behaviour:
- Reset (rst=1 at a clock edge) forces the following; reset overrides everything, including mid-operation:
  - state=IDLE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor registers=0.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1, annul_i=0, divisor_i!=0: latch operands, go to ON, cnt=0.
    - Signed mode: latch |dividend_i| and |divisor_i|, plus both sign bits. Two's-complement negate; 0x80000000 stays 0x80000000 and is treated as unsigned magnitude 2^31.
  - start_i=1, annul_i=0, divisor_i==0: go to BYZERO.
  - start_i=1 with annul_i=1: ignored, stay IDLE.
- BYZERO: next cycle go to END with result_o=0.
- ON: each cycle performs one restoring step on a 65-bit working register {partial remainder, dividend}:
  - Shift left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - cnt increments every cycle. On the cycle where cnt==DATA_W-1 completes, go to END.
  - Signed fixup is applied on the transition into END:
    - Quotient is negated if the dividend and divisor signs differ.
    - Remainder is negated if the dividend was negative.
    - All arithmetic wraps modulo 2^32, so 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - annul_i=1 in ON: go to IDLE next cycle; ready_o stays 0 and no result is produced.
- END: ready_o=1 and result_o is held stable.
  - start_i=0: go to IDLE; ready_o=0 and result_o=0 next cycle.
  - start_i=1: stay in END. A new divide cannot start until start_i has dropped for at least one cycle.
  - annul_i in END: go to IDLE, same as start_i=0.
- Latency:
  - Normal divide: start accepted in cycle T, 32 ON cycles (T+1..T+32), ready_o=1 in T+33.
  - Divide by zero: ready_o=1 in T+2.
- stallreq_o is low in the cycle ready_o is high. This lets EX retire the instruction, which drops start_i.
- cnt saturates at DATA_W and never wraps.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output div_zero_o (1 bit, registered, reset 0).
  - div_zero_o=1 together with ready_o when the result came via BYZERO; otherwise 0.
  - It clears when the block leaves END.
- Undefined:
  - Port absent.
  - Divide by zero silently returns result_o=0.

Decomposition:
- Shared package / defines file holds:
  - State encodings DIV_IDLE=2'b00, DIV_BYZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11.
  - DivResultBus width (63:0).
  - Constants DivStart, DivStop, DivResultReady, DivResultNotReady.
  - The existing ZeroWord/Stop/NoStop defines.
- One natural sub-module: div_step. It is combinational: one restoring iteration taking the 65-bit working register and the divisor, returning the next working register.

Test Plan:
- DIVU: 100 / 7, signed_i=0 -> ready_o rises exactly 33 cycles after accept; result_o = {32'd2, 32'd14}; stallreq_o high for cycles T..T+32, low at T+33.
- DIV: -7 / 2 (0xFFFFFFF9 / 0x00000002), signed_i=1 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); and 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero: 5 / 0 -> ready_o at T+2, result_o=0; with DIV_ZERO_FLAG_EN, div_zero_o=1 in the same cycle.
- Annul: start 100/7, assert annul_i at T+10 -> state IDLE at T+11, ready_o never rises; a fresh 9/3 issued afterwards returns {0, 3} 33 cycles after its accept.
- Hold in END: keep start_i high 5 extra cycles after ready -> result_o stable and ready_o=1 throughout; after start_i drops, ready_o=0 and result_o=0 next cycle.
- Reset mid-divide: assert rst at T+15 -> next cycle ready_o=0, result_o=0, state IDLE, stallreq_o follows start_i only.
